mux_arb_pipe: RTL and testbench
===============================

Name: mux_arb_pipe

Overview:
- Parametrised N:1 datapath multiplexer with one registered output stage and valid/ready handshakes on every input channel and on the output.
- Generalises the 2:1 32-bit select mux to CHANNELS inputs of WIDTH bits.
- Two grant modes:
  - Mode 0, select: a direct select input picks the channel.
  - Mode 1, round-robin: channels are served fairly in turn.
- Used wherever several producers share one datapath sink, e.g. write-back or memory-request paths.

Parameters:
- WIDTH, 32, data bits per channel.
- CHANNELS, 4, number of input channels; legal range 2..16.
- SEL_W, 2, select/channel-index width; must equal ceil(log2(CHANNELS)).

Ports:
- clk  input  1  system clock; rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- mode  input  1  0 = select mode, 1 = round-robin mode.
- sel  input  SEL_W  channel index used in select mode.
- in_data  input  CHANNELS*WIDTH  flattened channel data; channel i occupies bits [i*WIDTH +: WIDTH].
- in_valid  input  CHANNELS  per-channel valid.
- in_ready  output  CHANNELS  per-channel ready; one-hot or zero.
- out_data  output  WIDTH  registered output data.
- out_chan  output  SEL_W  index of the channel that produced out_data.
- out_valid  output  1  output holds a beat.
- out_ready  input  1  downstream accepts the beat.

Behaviour:
- Reset: clk is the only clock; rst_n is asynchronous, active-low. On reset:
  - out_valid = 0, out_data = 0, out_chan = 0.
  - Round-robin pointer rr_ptr = 0.
  - in_ready is combinational and is therefore 0 while out_valid = 0 and no grant exists.
- Load enable: load_en = !out_valid || out_ready. The block holds one beat; full throughput is 1 beat/cycle.
- Grant selection (combinational, each cycle):
  - Mode 0: gnt = sel when sel < CHANNELS, otherwise no grant. Out-of-range sel never drives data; this matches the old mux default-zero rule.
  - Mode 1: gnt = first channel with in_valid set, searching rr_ptr, rr_ptr+1, ..., wrapping modulo CHANNELS. No grant if no channel is valid.
- in_ready[gnt] = load_en. All other in_ready bits are 0. in_ready never depends on in_valid of the granted channel in mode 0.
- Transfer: occurs when in_valid[gnt] && in_ready[gnt]. At the next edge:
  - out_data <= in_data[gnt], out_chan <= gnt, out_valid <= 1.
  - Mode 1 only: rr_ptr <= (gnt+1) mod CHANNELS, wrapping from CHANNELS-1 to 0.
- Drain: out_valid && out_ready with no new transfer gives out_valid <= 0. out_data and out_chan retain their last value.
- Simultaneous drain and load in the same cycle: the new beat replaces the old one with no bubble.
- Back-pressure: while out_valid && !out_ready, out_data and out_chan are stable and all in_ready = 0.
- Latency: exactly 1 cycle from input acceptance to out_valid.
- rr_ptr is unchanged by:
  - cycles without a transfer;
  - mode-0 transfers.
- Mode or sel changes take effect on the grant in the same cycle. A beat already held in the output is unaffected.
- Reset mid-operation: any held beat is discarded immediately and asynchronously. No input is acknowledged during reset.

Optional Feature:
- Macro: MUX_ARB_PKT_LOCK_EN.
- When defined, added ports:
  - in_last  input  CHANNELS  per-channel end-of-packet flag.
  - out_last  output  1  registered alongside out_data; reset value 0.
- When defined, in mode 1, the grant locks to the current channel after any accepted beat with in_last = 0. It unlocks after an accepted beat with in_last = 1.
- While locked, rr_ptr does not advance. Lock state resets to unlocked.
- Mode 0 ignores the lock and only passes in_last through to out_last.
- When undefined: no extra ports; every beat is arbitrated independently.

Test Plan:
- Reset: hold rst_n = 0 with all in_valid = 1 → out_valid = 0, out_data = 0, in_ready = 0. Release → first beat appears 1 cycle after acceptance.
- Select mode: CHANNELS = 4, sel = 2, channel 2 data 0xDEADBEEF valid, out_ready = 1 → in_ready = 4'b0100; next cycle out_data = 0xDEADBEEF, out_chan = 2.
- Out-of-range select: CHANNELS = 3, sel = 3, all valid → in_ready = 0, out_valid stays 0.
- Round-robin fairness: mode = 1, all 4 channels valid continuously, out_ready = 1 → out_chan sequence 0,1,2,3,0,...; one beat per cycle, no bubbles.
- Back-pressure: out_ready = 0 for 5 cycles with a held beat 0x12345678 → out_data stable, all in_ready = 0. Assert out_ready → next channel loads in the same cycle the beat drains.
- Lock (MUX_ARB_PKT_LOCK_EN defined): channel 1 sends 3 beats with in_last = 0,0,1 while channel 2 is valid → out_chan = 1,1,1 then 2.

Source files
------------

// File: rtl/mux_arb_pipe.sv
// N:1 valid/ready multiplexer with one registered output stage; select or round-robin grant.
// Optional packet lock in round-robin mode when MUX_ARB_PKT_LOCK_EN is defined.
module mux_arb_pipe #(
    parameter int WIDTH    = 32,
    parameter int CHANNELS = 4,
    parameter int SEL_W    = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      mode,
    input  logic [SEL_W-1:0]          sel,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    input  logic [CHANNELS-1:0]       in_valid,
    output logic [CHANNELS-1:0]       in_ready,
    output logic [WIDTH-1:0]          out_data,
    output logic [SEL_W-1:0]          out_chan,
    output logic                      out_valid,
    input  logic                      out_ready
`ifdef MUX_ARB_PKT_LOCK_EN
    ,
    input  logic [CHANNELS-1:0]       in_last,
    output logic                      out_last
`endif
);

    localparam logic [SEL_W:0]   CH_L    = (SEL_W+1)'(CHANNELS);
    localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(CHANNELS - 1);

    logic [WIDTH-1:0]    r_out_data;
    logic [SEL_W-1:0]    r_out_chan;
    logic                r_out_valid;
    logic [SEL_W-1:0]    r_rr_ptr;
`ifdef MUX_ARB_PKT_LOCK_EN
    logic                r_out_last;
    logic                r_locked;
    logic [SEL_W-1:0]    r_lock_chan;
    logic                w_sel_last;
`endif

    logic [SEL_W-1:0]    w_gnt;
    logic                w_gnt_vld;
    logic [SEL_W:0]      w_idx;
    logic                w_load_en;
    logic [CHANNELS-1:0] w_in_ready;
    logic [WIDTH-1:0]    w_sel_data;
    logic                w_sel_valid;
    logic                w_xfer;
    logic [SEL_W-1:0]    w_next_ptr;

    // Grant selection: direct select, locked channel, or round-robin search from r_rr_ptr
    always_comb begin
        w_gnt     = '0;
        w_gnt_vld = 1'b0;
        w_idx     = '0;
        if (!mode) begin
            w_gnt     = sel;
            w_gnt_vld = ({1'b0, sel} < CH_L);
        end else begin
`ifdef MUX_ARB_PKT_LOCK_EN
            if (r_locked) begin
                w_gnt     = r_lock_chan;
                w_gnt_vld = 1'b1;
            end else
`endif
            begin
                // Walk offsets from far to near so the nearest valid channel wins last
                for (int k = CHANNELS - 1; k >= 0; k--) begin
                    w_idx = {1'b0, r_rr_ptr} + (SEL_W+1)'(k);
                    if (w_idx >= CH_L) begin
                        w_idx = w_idx - CH_L;
                    end else begin
                        w_idx = w_idx;
                    end
                    if (in_valid[w_idx[SEL_W-1:0]]) begin
                        w_gnt     = w_idx[SEL_W-1:0];
                        w_gnt_vld = 1'b1;
                    end else begin
                        w_gnt     = w_gnt;
                    end
                end
            end
        end
    end

    // Ready fan-out and data mux for the granted channel
    always_comb begin
        w_load_en   = !r_out_valid || out_ready;
        w_in_ready  = '0;
        w_sel_data  = '0;
        w_sel_valid = 1'b0;
`ifdef MUX_ARB_PKT_LOCK_EN
        w_sel_last  = 1'b0;
`endif
        for (int i = 0; i < CHANNELS; i++) begin
            if (w_gnt_vld && (w_gnt == SEL_W'(i))) begin
                w_in_ready[i] = w_load_en && rst_n;
                w_sel_data    = in_data[i*WIDTH +: WIDTH];
                w_sel_valid   = in_valid[i];
`ifdef MUX_ARB_PKT_LOCK_EN
                w_sel_last    = in_last[i];
`endif
            end else begin
                w_in_ready[i] = 1'b0;
            end
        end
        w_xfer = w_sel_valid && (|w_in_ready);
        if (w_gnt == LAST_CH) begin
            w_next_ptr = '0;
        end else begin
            w_next_ptr = w_gnt + SEL_W'(1);
        end
    end

    // Output stage: load on transfer, clear valid on drain, otherwise hold
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_data  <= '0;
            r_out_chan  <= '0;
            r_out_valid <= 1'b0;
`ifdef MUX_ARB_PKT_LOCK_EN
            r_out_last  <= 1'b0;
`endif
        end else if (w_xfer) begin
            r_out_data  <= w_sel_data;
            r_out_chan  <= w_gnt;
            r_out_valid <= 1'b1;
`ifdef MUX_ARB_PKT_LOCK_EN
            r_out_last  <= w_sel_last;
`endif
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= r_out_valid;
        end
    end

    // Round-robin pointer (and packet lock) advance only on mode-1 transfers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_ptr    <= '0;
`ifdef MUX_ARB_PKT_LOCK_EN
            r_locked    <= 1'b0;
            r_lock_chan <= '0;
`endif
        end else if (w_xfer && mode) begin
`ifdef MUX_ARB_PKT_LOCK_EN
            if (w_sel_last) begin
                r_locked <= 1'b0;
                r_rr_ptr <= w_next_ptr;
            end else begin
                r_locked    <= 1'b1;
                r_lock_chan <= w_gnt;
            end
`else
            r_rr_ptr <= w_next_ptr;
`endif
        end else begin
            r_rr_ptr <= r_rr_ptr;
        end
    end

    assign in_ready  = w_in_ready;
    assign out_data  = r_out_data;
    assign out_chan  = r_out_chan;
    assign out_valid = r_out_valid;
`ifdef MUX_ARB_PKT_LOCK_EN
    assign out_last  = r_out_last;
`endif

endmodule

// File: tb/tb_mux_arb_pipe.sv
// Scoreboard bench for mux_arb_pipe: a 4-channel instance driven through all modes,
// plus a 3-channel instance for the out-of-range select case.
module tb_mux_arb_pipe;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         mode;
    logic [1:0]   sel;
    logic [127:0] in_data;
    logic [3:0]   in_valid;
    logic [3:0]   in_ready;
    logic [31:0]  out_data;
    logic [1:0]   out_chan;
    logic         out_valid;
    logic         out_ready;

    logic         mode3;
    logic [1:0]   sel3;
    logic [95:0]  in_data3;
    logic [2:0]   in_valid3;
    logic [2:0]   in_ready3;
    logic [31:0]  out_data3;
    logic [1:0]   out_chan3;
    logic         out_valid3;
    logic         out_ready3;
`ifdef MUX_ARB_PKT_LOCK_EN
    logic [3:0]   in_last;
    logic         out_last;
    logic [2:0]   in_last3;
    logic         out_last3;
`endif

    int checks = 0;
    int errors = 0;

    // Model state
    bit           m_valid;
    int           m_rr;
    bit           m_locked;
    int           m_lock_ch;
    logic [34:0]  q[$];

    always #5 clk = ~clk;

    mux_arb_pipe #(.WIDTH(32), .CHANNELS(4), .SEL_W(2)) u_dut (
        .clk(clk), .rst_n(rst_n), .mode(mode), .sel(sel),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_chan(out_chan), .out_valid(out_valid),
        .out_ready(out_ready)
`ifdef MUX_ARB_PKT_LOCK_EN
        , .in_last(in_last), .out_last(out_last)
`endif
    );

    mux_arb_pipe #(.WIDTH(32), .CHANNELS(3), .SEL_W(2)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .mode(mode3), .sel(sel3),
        .in_data(in_data3), .in_valid(in_valid3), .in_ready(in_ready3),
        .out_data(out_data3), .out_chan(out_chan3), .out_valid(out_valid3),
        .out_ready(out_ready3)
`ifdef MUX_ARB_PKT_LOCK_EN
        , .in_last(in_last3), .out_last(out_last3)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic set_data(input int c, input logic [31:0] d);
        in_data[c*32 +: 32] = d;
    endtask

    // Called #0 after a negedge with inputs driven; checks, updates model, returns at next negedge
    task automatic cycle();
        int          g;
        bit          ok;
        bit          load;
        bit          xfer;
        bit          lst;
        logic [3:0]  exp_rdy;
        logic [34:0] e;
        #1;
        load = !m_valid || out_ready;
        ok   = 1'b0;
        g    = 0;
        lst  = 1'b0;
        if (rst_n) begin
            if (!mode) begin
                g  = int'(sel);
                ok = (g < 4);
            end else if (m_locked) begin
                g  = m_lock_ch;
                ok = 1'b1;
            end else begin
                for (int k = 0; k < 4; k++) begin
                    if (!ok && in_valid[(m_rr + k) % 4]) begin
                        ok = 1'b1;
                        g  = (m_rr + k) % 4;
                    end
                end
            end
        end
        exp_rdy = (ok && load) ? (4'b0001 << g) : 4'b0000;
        chk("in_ready", {60'd0, in_ready}, {60'd0, exp_rdy});
        chk("out_valid", {63'd0, out_valid}, {63'd0, m_valid});
        if (m_valid && q.size() > 0) begin
            e = q[0];
            chk("out_data", {32'd0, out_data}, {32'd0, e[31:0]});
            chk("out_chan", {62'd0, out_chan}, {62'd0, e[33:32]});
`ifdef MUX_ARB_PKT_LOCK_EN
            chk("out_last", {63'd0, out_last}, {63'd0, e[34]});
`endif
            if (out_ready) begin
                void'(q.pop_front());
            end
        end
        xfer = ok && load && in_valid[g];
`ifdef MUX_ARB_PKT_LOCK_EN
        lst = in_last[g];
`endif
        if (xfer) begin
            q.push_back({lst, 2'(g), in_data[g*32 +: 32]});
            if (mode) begin
`ifdef MUX_ARB_PKT_LOCK_EN
                if (lst) begin
                    m_locked = 1'b0;
                    m_rr     = (g + 1) % 4;
                end else begin
                    m_locked  = 1'b1;
                    m_lock_ch = g;
                end
`else
                m_rr = (g + 1) % 4;
`endif
            end
        end
        m_valid = xfer || (m_valid && !out_ready);
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0; mode = 1'b0; sel = 2'd0; in_data = '0; in_valid = 4'hF; out_ready = 1'b1;
        mode3 = 1'b0; sel3 = 2'd3; in_data3 = '0; in_valid3 = 3'b111; out_ready3 = 1'b1;
`ifdef MUX_ARB_PKT_LOCK_EN
        in_last = 4'hF; in_last3 = 3'b111;
`endif
        m_valid = 1'b0; m_rr = 0; m_locked = 1'b0; m_lock_ch = 0;
        for (int c = 0; c < 4; c++) set_data(c, 32'hA000_0000 + 32'(c));

        // Reset held with every channel valid
        repeat (2) @(negedge clk);
        #1;
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_out_data", {32'd0, out_data}, 64'd0);
        chk("rst_out_chan", {62'd0, out_chan}, 64'd0);
        chk("rst_in_ready", {60'd0, in_ready}, 64'd0);
        chk("rst_in_ready3", {61'd0, in_ready3}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Select mode: channel 2
        sel = 2'd2; set_data(2, 32'hDEAD_BEEF);
        cycle();
        in_valid = 4'h0;
        cycle();
        sel = 2'd1;
        cycle();

        // Three-channel instance: out-of-range select never grants
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("oor_in_ready", {61'd0, in_ready3}, 64'd0);
            chk("oor_out_valid", {63'd0, out_valid3}, 64'd0);
            @(negedge clk);
        end
        sel3 = 2'd2; in_data3[64 +: 32] = 32'hCAFE_0002;
        #1;
        chk("c3_in_ready", {61'd0, in_ready3}, 64'h4);
        @(negedge clk);
        in_valid3 = 3'b000;
        #1;
        chk("c3_out_valid", {63'd0, out_valid3}, 64'd1);
        chk("c3_out_chan", {62'd0, out_chan3}, 64'd2);
        chk("c3_out_data", {32'd0, out_data3}, 64'hCAFE_0002);
        @(negedge clk);

        // Round-robin with all channels valid
        mode = 1'b1; in_valid = 4'hF;
`ifdef MUX_ARB_PKT_LOCK_EN
        in_last = 4'hF;
`endif
        for (int i = 0; i < 10; i++) begin
            for (int c = 0; c < 4; c++) set_data(c, {8'(c), 24'(i)});
            cycle();
        end

        // Back-pressure on a held 0x12345678 beat
        mode = 1'b0; sel = 2'd0; set_data(0, 32'h1234_5678);
        cycle();
        out_ready = 1'b0; set_data(0, 32'h5555_0000); sel = 2'd1; set_data(1, 32'h0BAD_F00D);
        repeat (5) cycle();
        out_ready = 1'b1;
        cycle();
        in_valid = 4'h0;
        repeat (2) cycle();

`ifdef MUX_ARB_PKT_LOCK_EN
        // Packet lock: channel 1 sends 3 beats, channel 2 waits
        mode = 1'b1; in_valid = 4'b0010; in_last = 4'b0100;
        set_data(1, 32'h1111_0000); set_data(2, 32'h2222_0000);
        cycle();
        in_valid = 4'b0110; set_data(1, 32'h1111_0001);
        cycle();
        in_last = 4'b0110; set_data(1, 32'h1111_0002);
        cycle();
        in_valid = 4'b0100;
        cycle();
        in_valid = 4'h0;
        repeat (2) cycle();
`endif

        // Random traffic, mode/sel switching and back-pressure
        for (int i = 0; i < 80; i++) begin
            mode      = 1'($urandom_range(0, 1));
            sel       = 2'($urandom_range(0, 3));
            in_valid  = 4'($urandom_range(0, 15));
            out_ready = ($urandom_range(0, 3) != 0);
            for (int c = 0; c < 4; c++) set_data(c, $urandom);
`ifdef MUX_ARB_PKT_LOCK_EN
            in_last   = 4'($urandom_range(0, 15));
`endif
            cycle();
        end

        // Drain
        in_valid = 4'h0; out_ready = 1'b1;
        repeat (2) cycle();
        chk("q_empty", 64'(q.size()), 64'd0);

        // Asynchronous reset while a beat is held
        mode = 1'b0; sel = 2'd3; in_valid = 4'h8; set_data(3, 32'h7777_7777);
        cycle();
        out_ready = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("arst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("arst_in_ready", {60'd0, in_ready}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
